// File: rtl/beam_pkg.sv
// Shared constants for the beam summing pipeline: frame FSM states and
// output mode codes.
package beam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } beam_state_t;

    localparam logic [1:0] MODE_SUM     = 2'd0;
    localparam logic [1:0] MODE_MEAN    = 2'd1;
    localparam logic [1:0] MODE_SAT     = 2'd2;
    localparam logic [1:0] MODE_SUM_ALT = 2'd3;

endpackage

// File: rtl/beam_add_stage.sv
// One level of the registered adder tree: adds adjacent pairs of signed
// operands with one bit of growth, holding its contents while en is low.
module beam_add_stage #(
    parameter int N_IN = 2,
    parameter int W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [N_IN*W-1:0]            in_data,
    output logic                         out_valid,
    output logic [(N_IN/2)*(W+1)-1:0]    out_data
);

    logic [(N_IN/2)*(W+1)-1:0] pair_sum_s;
    logic                      valid_r;
    logic [(N_IN/2)*(W+1)-1:0] data_r;

    // Full-precision pairwise sums of the sign-extended operands.
    always_comb begin
        pair_sum_s = '0;
        for (int p = 0; p < N_IN / 2; p++) begin
            pair_sum_s[p*(W+1) +: (W+1)] =
                (W+1)'($signed(in_data[(2*p)*W +: W])) +
                (W+1)'($signed(in_data[(2*p+1)*W +: W]));
        end
    end

    // Stage register; data only updates on a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (en) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= pair_sum_s;
            end
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/beam_sum_pipe.sv
// Frame-based multichannel beam summer: masked channels are reduced by a
// registered binary adder tree, then post-processed (sum/mean/saturate).
module beam_sum_pipe
    import beam_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 40,
    parameter int FRAME_LEN = 540
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NCH-1:0]        chan_mask,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*IN_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int LOG2  = $clog2(NCH);
    localparam int SUM_W = IN_W + LOG2;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic signed [SUM_W-1:0] SAT_HI = {{(LOG2+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO = {{(LOG2+1){1'b1}}, {(IN_W-1){1'b0}}};
    localparam logic signed [SUM_W:0]   MEAN_HALF = (SUM_W+1)'(2 ** (LOG2 - 1));

    beam_state_t          state_r, state_s;
    logic [CNT_W-1:0]     in_cnt_r, out_cnt_r;
    logic [NCH-1:0]       mask_r;
    logic [1:0]           mode_r;
    logic                 busy_r, done_r, overflow_r;
    logic                 out_valid_r, out_last_r;
    logic [OUT_W-1:0]     out_data_r;

    logic                 start_ok_s, stall_s, in_ready_s, in_fire_s, out_fire_s;
    logic [NCH*IN_W-1:0]  masked_s;
    logic                 last_valid_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W:0]   mean_acc_s, mean_shift_s;
    logic [OUT_W-1:0]     result_s;
    logic                 sat_hit_s;

    assign start_ok_s = start && (state_r == ST_IDLE);
    assign stall_s    = out_valid_r && !out_ready;
    assign in_ready_s = (state_r == ST_RUN) && (in_cnt_r < CNT_W'(FRAME_LEN)) && !stall_s;
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = out_valid_r && out_ready;

    // Zero out disabled channels before they enter the tree.
    always_comb begin
        masked_s = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mask_r[k]) begin
                masked_s[k*IN_W +: IN_W] = in_data[k*IN_W +: IN_W];
            end else begin
                masked_s[k*IN_W +: IN_W] = '0;
            end
        end
    end

    // Tree level l holds NCH>>l operands of IN_W+l bits each.
    for (genvar l = 0; l <= LOG2; l++) begin : g_lvl
        localparam int N = NCH >> l;
        localparam int W = IN_W + l;
        logic [N*W-1:0] data;
        logic           valid;
        if (l == 0) begin : g_in
            assign data  = masked_s;
            assign valid = in_fire_s;
        end else begin : g_add
            beam_add_stage #(
                .N_IN (NCH >> (l - 1)),
                .W    (IN_W + l - 1)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (!stall_s),
                .in_valid  (g_lvl[l-1].valid),
                .in_data   (g_lvl[l-1].data),
                .out_valid (valid),
                .out_data  (data)
            );
        end
    end

    assign last_valid_s = g_lvl[LOG2].valid;
    assign sum_s        = $signed(g_lvl[LOG2].data);
    assign mean_acc_s   = $signed({sum_s[SUM_W-1], sum_s}) + MEAN_HALF;
    assign mean_shift_s = mean_acc_s >>> LOG2;

    // Output post-processing selected by the latched mode.
    always_comb begin
        result_s  = '0;
        sat_hit_s = 1'b0;
        case (mode_r)
            MODE_MEAN: result_s = OUT_W'(mean_shift_s);
            MODE_SAT: begin
                if (sum_s > SAT_HI) begin
                    result_s  = OUT_W'(SAT_HI);
                    sat_hit_s = 1'b1;
                end else if (sum_s < SAT_LO) begin
                    result_s  = OUT_W'(SAT_LO);
                    sat_hit_s = 1'b1;
                end else begin
                    result_s  = OUT_W'(sum_s);
                end
            end
            default: result_s = OUT_W'(sum_s);
        endcase
    end

    // Frame sequencing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (in_fire_s && (in_cnt_r == CNT_W'(FRAME_LEN - 1))) state_s = ST_DRAIN;
                else                                                   state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (out_fire_s && out_last_r) state_s = ST_DONE;
                else                          state_s = ST_DRAIN;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register with busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Frame configuration latch and input transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_r <= '0;
            mask_r   <= '0;
            mode_r   <= MODE_SUM;
        end else if (start_ok_s) begin
            in_cnt_r <= '0;
            mask_r   <= chan_mask;
            mode_r   <= mode;
        end else if (in_fire_s) begin
            in_cnt_r <= in_cnt_r + CNT_W'(1);
        end
    end

    // Output register; out_last tags the FRAME_LEN-th loaded beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_cnt_r   <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (start_ok_s) begin
                out_cnt_r  <= '0;
                overflow_r <= 1'b0;
            end
            if (!stall_s) begin
                out_valid_r <= last_valid_s;
                if (last_valid_s) begin
                    out_data_r <= result_s;
                    out_last_r <= (out_cnt_r == CNT_W'(FRAME_LEN - 1));
                    out_cnt_r  <= out_cnt_r + CNT_W'(1);
                    if (sat_hit_s) begin
                        overflow_r <= 1'b1;
                    end
                end else begin
                    out_last_r <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_beam_sum_pipe.sv
// Directed self-checking bench for beam_sum_pipe (NCH=8, IN_W=32, OUT_W=40,
// FRAME_LEN=540) with a reference model and an in-order scoreboard.
module tb_beam_sum_pipe;
    import beam_pkg::*;

    localparam int NCH       = 8;
    localparam int IN_W      = 32;
    localparam int OUT_W     = 40;
    localparam int FRAME_LEN = 540;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [NCH-1:0]       chan_mask;
    logic [1:0]           mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*IN_W-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int n_checks = 0;
    int n_fail   = 0;

    beam_sum_pipe #(
        .NCH       (NCH),
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chan_mask (chan_mask),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*IN_W-1:0] make_beat(input int pat, input int idx);
        logic [NCH*IN_W-1:0] d;
        logic [31:0]         v;
        d = '0;
        for (int k = 0; k < NCH; k++) begin
            case (pat)
                0: v = 32'd100;
                1: begin
                    case (idx % 3)
                        0:       v = (k == 0) ? 32'd7 : 32'd0;
                        1:       v = -32'sd3;
                        default: v = 32'(-(k + idx % 5));
                    endcase
                end
                2: begin
                    case (idx % 4)
                        1:       v = 32'h8000_0000;
                        2:       v = 32'(k * 1000 - 3000);
                        default: v = 32'h7FFF_FFFF;
                    endcase
                end
                3:       v = 32'(k + 1);
                default: v = $urandom;
            endcase
            d[k*IN_W +: IN_W] = v;
        end
        return d;
    endfunction

    function automatic logic [OUT_W-1:0] model(input logic [NCH*IN_W-1:0] d,
                                               input logic [NCH-1:0] msk,
                                               input logic [1:0] m);
        longint s;
        longint r;
        s = 64'sd0;
        for (int k = 0; k < NCH; k++) begin
            if (msk[k]) s += longint'($signed(d[k*IN_W +: IN_W]));
        end
        case (m)
            2'd1:    r = (s + 64'sd4) >>> 3;
            2'd2:    r = (s > 64'sd2147483647) ? 64'sd2147483647 :
                         (s < -64'sd2147483648) ? -64'sd2147483648 : s;
            default: r = s;
        endcase
        return r[OUT_W-1:0];
    endfunction

    task automatic run_frame(input logic [1:0] m, input logic [NCH-1:0] msk, input int pat,
                             input bit rnd_ready, input int abort_beat, input bit exp_ovf);
        int sent, got, cyc, first_fire, first_out;
        bit hold_pending, drain_seen, aborted;
        logic [OUT_W-1:0] hold_data;
        logic hold_last;
        logic [OUT_W-1:0] expq[$];
        @(negedge clk);
        start = 1'b1; mode = m; chan_mask = msk; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("overflow_cleared_at_start", 64'(overflow), 64'd0);
        sent = 0; got = 0; cyc = 0; first_fire = -1; first_out = -1;
        hold_pending = 1'b0; drain_seen = 1'b0; aborted = 1'b0;
        hold_data = '0; hold_last = 1'b0;
        while (got < FRAME_LEN && cyc < 5000) begin
            if (abort_beat > 0 && got >= abort_beat) begin
                aborted = 1'b1;
                break;
            end
            if (hold_pending) begin
                chk("stall_valid_held", 64'(out_valid), 64'd1);
                chk("stall_data_held", 64'(out_data), 64'(hold_data));
                chk("stall_last_held", 64'(out_last), 64'(hold_last));
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (sent == FRAME_LEN && !drain_seen) begin
                drain_seen = 1'b1;
                chk("in_ready_low_in_drain", 64'(in_ready), 64'd0);
                chk("busy_in_drain", 64'(busy), 64'd1);
            end
            out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid  = (sent < FRAME_LEN);
            in_data   = make_beat(pat, sent);
            if (cyc == 50) begin
                start = 1'b1; mode = ~m; chan_mask = ~msk;
            end
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, msk, m));
                if (first_fire < 0) first_fire = cyc;
                sent++;
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_last    = out_last;
            if (out_valid && out_ready) begin
                got++;
                chk("beat_expected", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) chk("beat_data", 64'(out_data), 64'(expq.pop_front()));
                chk("beat_last", 64'(out_last), 64'(got == FRAME_LEN));
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!aborted) begin
            chk("frame_beats", 64'(got), 64'(FRAME_LEN));
            chk("frame_inputs", 64'(sent), 64'(FRAME_LEN));
            chk("first_beat_latency", 64'(first_out - first_fire), 64'd4);
            chk("done_pulse", 64'(done), 64'd1);
            chk("busy_low_in_done", 64'(busy), 64'd0);
            chk("overflow_at_end", 64'(overflow), 64'(exp_ovf));
            in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("in_ready_low_idle", 64'(in_ready), 64'd0);
            chk("overflow_sticky", 64'(overflow), 64'(exp_ovf));
        end
    endtask

    task automatic check_all_zero(input string ctx);
        chk({ctx, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({ctx, "_out_last"},  64'(out_last),  64'd0);
        chk({ctx, "_out_data"},  64'(out_data),  64'd0);
        chk({ctx, "_busy"},      64'(busy),      64'd0);
        chk({ctx, "_done"},      64'(done),      64'd0);
        chk({ctx, "_overflow"},  64'(overflow),  64'd0);
        chk({ctx, "_in_ready"},  64'(in_ready),  64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; chan_mask = '0; mode = 2'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_frame(MODE_SUM,     8'hFF, 0, 1'b0, 0, 1'b0);
        run_frame(MODE_MEAN,    8'hFF, 1, 1'b0, 0, 1'b0);
        run_frame(MODE_SAT,     8'hFF, 2, 1'b0, 0, 1'b1);
        run_frame(MODE_SUM_ALT, 8'h0F, 3, 1'b0, 0, 1'b0);
        run_frame(MODE_SUM,     8'hFF, 4, 1'b1, 0, 1'b0);

        run_frame(MODE_SAT,     8'hFF, 2, 1'b0, 200, 1'b1);
        chk("overflow_before_abort", 64'(overflow), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_beat_after_reset", 64'(out_valid), 64'd0);
            chk("no_ready_after_reset", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        run_frame(MODE_SUM, 8'hFF, 0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
